// File: rtl/sc_pkg.sv
// Shared decode definitions for the sc_comp single-cycle RV32I-subset computer.
// Contents: opcode and funct3 constants, ALU operation, immediate format and
// write-back source enums, plus immediate-generation and ALU-select helpers.
package sc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Load/store funct3
  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_SB   = 3'd0;
  localparam logic [2:0] F3_SW   = 3'd2;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4, WbImm} wb_sel_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      ImmS:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ImmB:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ImmU:    imm = {ins[31:12], 12'b0};
      ImmJ:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

  // alt selects sub (for add) or arithmetic shift (for shift-right).
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? AluSub : AluAdd;
      F3_SLL:  op = AluSll;
      F3_SLT:  op = AluSlt;
      F3_SLTU: op = AluSltu;
      F3_XOR:  op = AluXor;
      F3_SR:   op = alt ? AluSra : AluSrl;
      F3_OR:   op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sc_comp_if.sv
// Data-memory bus between the core (master) and the byte-addressed RAM (slave).
// addr: byte address; wdata: store data placed on byte lanes; be: per-lane write
// enables; rdata: aligned 32-bit word containing addr, little-endian.
interface sc_comp_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output be, input rdata);
  modport slave  (input addr, input wdata, input be, output rdata);
endinterface

// File: rtl/sc_cpu.sv
// Single-cycle RV32I-subset core with its register file (U_RF).
// Ports: clk; rstn (synchronous, active-high); inst_in fetched instruction;
// PC_out current PC; reg_sel/reg_data debug read; dbus data-memory master.
// Option: SCCOMP_ECALL_HALT_EN makes ecall and unsupported encodings freeze the PC
// with no writes (until reset); otherwise they retire as NOPs.
module sc_cpu
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst_in,
  output logic [31:0] PC_out,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data,
  sc_comp_if.master   dbus
);

  logic [31:0] pc_q;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign funct3 = inst_in[14:12];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign funct7 = inst_in[31:25];

  logic        valid, reg_write, mem_write, is_branch, is_jal, is_jalr;
  logic        alu_a_pc, alu_b_imm;
  imm_type_e   imm_type;
  wb_sel_e     wb_sel;
  alu_op_e     alu_op;

  always_comb begin
    valid     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    imm_type  = ImmI;
    wb_sel    = WbAlu;
    alu_op    = AluAdd;
    case (opcode)
      OP_R: begin
        valid     = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        reg_write = 1'b1;
        alu_op    = alu_op_from_f3(funct3, funct7[5]);
      end
      OP_I: begin
        case (funct3)
          F3_SLL:  valid = (funct7 == 7'h00);
          F3_SR:   valid = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: valid = 1'b1;
        endcase
        reg_write = 1'b1;
        alu_b_imm = 1'b1;
        // Upper immediate bits only mean "arithmetic" for shift-right.
        alu_op    = alu_op_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
      end
      OP_LOAD: begin
        valid     = (funct3 == F3_LB) || (funct3 == F3_LW) || (funct3 == F3_LBU);
        reg_write = 1'b1;
        alu_b_imm = 1'b1;
        wb_sel    = WbMem;
      end
      OP_STORE: begin
        valid     = (funct3 == F3_SB) || (funct3 == F3_SW);
        mem_write = 1'b1;
        alu_b_imm = 1'b1;
        imm_type  = ImmS;
      end
      OP_BRANCH: begin
        valid     = (funct3 != 3'd2) && (funct3 != 3'd3);
        is_branch = 1'b1;
        imm_type  = ImmB;
      end
      OP_JAL: begin
        valid     = 1'b1;
        is_jal    = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WbPc4;
        imm_type  = ImmJ;
      end
      OP_JALR: begin
        valid     = (funct3 == 3'd0);
        is_jalr   = 1'b1;
        reg_write = 1'b1;
        alu_b_imm = 1'b1;
        wb_sel    = WbPc4;
      end
      OP_LUI: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WbImm;
        imm_type  = ImmU;
      end
      OP_AUIPC: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        alu_a_pc  = 1'b1;
        alu_b_imm = 1'b1;
        imm_type  = ImmU;
      end
      default: valid = 1'b0;
    endcase
    if (!valid) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
    end
  end

  logic halt;
`ifdef SCCOMP_ECALL_HALT_EN
  // ecall is not a valid encoding here, so it halts along with other unsupported ones.
  assign halt = !valid;
`else
  assign halt = 1'b0;
`endif

  logic [31:0] imm, rs1_data, rs2_data, wb_data, pc_plus4;
  logic        rf_we;

  assign imm      = gen_imm(inst_in, imm_type);
  assign pc_plus4 = pc_q + 32'd4;
  assign rf_we    = reg_write && !rstn && !halt;

  sc_rf U_RF (
    .clk      (clk),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (wb_data),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .dbg_addr (reg_sel),
    .rdata1   (rs1_data),
    .rdata2   (rs2_data),
    .dbg_data (reg_data)
  );

  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  shamt;

  assign alu_a = alu_a_pc  ? pc_q : rs1_data;
  assign alu_b = alu_b_imm ? imm  : rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      AluAdd:  alu_res = alu_a + alu_b;
      AluSub:  alu_res = alu_a - alu_b;
      AluSll:  alu_res = alu_a << shamt;
      AluSlt:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      AluSltu: alu_res = {31'd0, alu_a < alu_b};
      AluXor:  alu_res = alu_a ^ alu_b;
      AluSrl:  alu_res = alu_a >> shamt;
      AluSra:  alu_res = $signed(alu_a) >>> shamt;
      AluOr:   alu_res = alu_a | alu_b;
      AluAnd:  alu_res = alu_a & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (rs1_data == rs2_data);
      F3_BNE:  br_cond = (rs1_data != rs2_data);
      F3_BLT:  br_cond = $signed(rs1_data) < $signed(rs2_data);
      F3_BGE:  br_cond = $signed(rs1_data) >= $signed(rs2_data);
      F3_BLTU: br_cond = rs1_data < rs2_data;
      F3_BGEU: br_cond = rs1_data >= rs2_data;
      default: br_cond = 1'b0;
    endcase
  end

  // Data memory: the RAM returns the aligned word, the core selects the byte lane.
  logic [7:0]  ld_byte;
  logic [31:0] ld_data;

  assign dbus.addr  = alu_res;
  assign dbus.wdata = (funct3 == F3_SW) ? rs2_data : {4{rs2_data[7:0]}};
  assign dbus.be    = (!mem_write || rstn) ? 4'b0000 :
                      (funct3 == F3_SW)    ? 4'b1111 : (4'b0001 << alu_res[1:0]);

  assign ld_byte = 8'(dbus.rdata >> {alu_res[1:0], 3'b000});

  always_comb begin
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'd0, ld_byte};
      default: ld_data = dbus.rdata;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WbMem:   wb_data = ld_data;
      WbPc4:   wb_data = pc_plus4;
      WbImm:   wb_data = imm;
      default: wb_data = alu_res;
    endcase
  end

  logic [31:0] pc_d;
  always_comb begin
    pc_d = pc_plus4;
    if (halt) begin
      pc_d = pc_q;
    end else if (is_jalr) begin
      pc_d = alu_res & ~32'd1;
    end else if (is_jal || (is_branch && br_cond)) begin
      pc_d = pc_q + imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_out = pc_q;

endmodule

// File: rtl/sc_dm.sv
// Byte-addressed little-endian data RAM; address taken modulo DM_BYTES.
// Ports: clk; dbus slave (word-aligned combinational read, byte-lane writes on posedge).
module sc_dm #(
  parameter int unsigned DM_BYTES = 512
) (
  input logic       clk,
  sc_comp_if.slave  dbus
);

  localparam int unsigned AW = $clog2(DM_BYTES);

  logic [7:0]    dmem [0:DM_BYTES-1];
  logic [AW-1:0] word_base;

  assign word_base = {dbus.addr[AW-1:2], 2'b00};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dbus.be[i]) begin
        dmem[word_base | AW'(i)] <= dbus.wdata[8*i +: 8];
      end
    end
  end

  assign dbus.rdata = {dmem[word_base | AW'(3)], dmem[word_base | AW'(2)],
                       dmem[word_base | AW'(1)], dmem[word_base]};

  logic unused_addr;
  assign unused_addr = ^{dbus.addr[31:AW], dbus.addr[1:0]};

endmodule

// File: rtl/sc_im.sv
// Instruction ROM, combinational fetch. Contents are loaded externally into ROM.
// Ports: pc (byte address, wraps through the word-index bits), instr.
module sc_im #(
  parameter int unsigned IM_WORDS = 512
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);

  localparam int unsigned AW = $clog2(IM_WORDS);

  logic [31:0] ROM [0:IM_WORDS-1];

  assign instr = ROM[pc[AW+1:2]];

  logic unused_pc;
  assign unused_pc = ^{pc[31:AW+2], pc[1:0]};

endmodule

// File: rtl/sc_rf.sv
// 31 x 32-bit register file, x0 hardwired to zero.
// Ports: clk; we/waddr/wdata synchronous write; raddr1/raddr2 and dbg_addr
// asynchronous reads (rdata1/rdata2/dbg_data). Same-cycle reads see old data.
module sc_rf (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] dbg_data
);

  logic [31:0] rf [1:31];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1 == 5'd0)   ? 32'd0 : rf[raddr1];
  assign rdata2   = (raddr2 == 5'd0)   ? 32'd0 : rf[raddr2];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

endmodule

// File: rtl/sc_comp.sv
// Top of the single-cycle RV32I-subset computer: core U_SCPU (with U_RF),
// instruction ROM U_IM and data RAM U_DM joined by an sc_comp_if bus.
// Ports: clk; rstn synchronous active-high reset; reg_sel/reg_data debug read
// of x[reg_sel]. Option macro: SCCOMP_ECALL_HALT_EN (see sc_cpu).
module sc_comp #(
  parameter int unsigned IM_WORDS = 512,
  parameter int unsigned DM_BYTES = 512,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  logic [31:0] PC;
  logic [31:0] instr;

  sc_comp_if dbus ();

  sc_cpu #(
    .RESET_PC (RESET_PC)
  ) U_SCPU (
    .clk      (clk),
    .rstn     (rstn),
    .inst_in  (instr),
    .PC_out   (PC),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .dbus     (dbus)
  );

  sc_im #(
    .IM_WORDS (IM_WORDS)
  ) U_IM (
    .pc    (PC),
    .instr (instr)
  );

  sc_dm #(
    .DM_BYTES (DM_BYTES)
  ) U_DM (
    .clk  (clk),
    .dbus (dbus)
  );

endmodule

// File: tb/tb_sc_comp.sv
// Directed self-checking bench for sc_comp: small programs are placed in the ROM,
// executed for a fixed number of cycles and checked against hand-derived values.
module tb_sc_comp;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int n_checks = 0;
  int n_errors = 0;

  sc_comp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                        input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  localparam logic [31:0] JSELF = 32'h0000_006f;  // jal x0,0

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) dut.U_IM.ROM[i] = 32'h0000_0013;
  endtask

  task automatic put(input int addr, input logic [31:0] ins);
    dut.U_IM.ROM[addr / 4] = ins;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reg(input string tag, input int r, input logic [31:0] exp);
    reg_sel = 5'(r);
    #1;
    check(tag, reg_data, exp);
  endtask

  // One reset edge, then release.
  task automatic reset_core();
    rstn = 1'b1;
    step(1);
    rstn = 1'b0;
  endtask

  logic [31:0] pc_trace [12];

  initial begin
    // ---------------- reset + ALU ----------------
    clear_rom();
    put('h00, 32'h0050_0093);             // addi x1,x0,5
    put('h04, 32'hffd0_0113);             // addi x2,x0,-3
    put('h08, 32'h0020_81b3);             // add  x3,x1,x2
    put('h0c, enc_r('h20, 2, 1, 0, 4));   // sub  x4,x1,x2
    put('h10, enc_r(0, 1, 2, 2, 5));      // slt  x5,x2,x1
    put('h14, enc_r(0, 1, 2, 3, 6));      // sltu x6,x2,x1
    put('h18, JSELF);
    reset_core();
    check("reset_pc", dut.PC, 32'h0);
    check("reset_instr", dut.instr, 32'h0050_0093);
    step(1);
    check("pc_4", dut.PC, 32'h4);
    check("cpu_pc_out", dut.U_SCPU.PC_out, 32'h4);
    step(1);
    check("pc_8", dut.PC, 32'h8);
    check("cpu_inst_in", dut.U_SCPU.inst_in, 32'h0020_81b3);
    step(6);
    check("alu_loop_pc", dut.PC, 32'h18);
    check_reg("alu_x1", 1, 32'd5);
    check_reg("alu_x2", 2, 32'hffff_fffd);
    check_reg("alu_add", 3, 32'd2);
    check_reg("alu_sub", 4, 32'd8);
    check_reg("alu_slt", 5, 32'd1);
    check_reg("alu_sltu", 6, 32'd0);

    // ---------------- memory ----------------
    rstn = 1'b1;
    clear_rom();
    put('h00, enc_u('h12345, 1, 'h37));   // lui  x1,0x12345
    put('h04, addi(1, 1, 'h678));         // addi x1,x1,0x678
    put('h08, enc_s(0, 1, 0, 2));         // sw   x1,0(x0)
    put('h0c, enc_i(0, 0, 0, 2, 'h03));   // lb   x2,0(x0)
    put('h10, enc_i(3, 0, 4, 3, 'h03));   // lbu  x3,3(x0)
    put('h14, enc_s(5, 1, 0, 0));         // sb   x1,5(x0)
    put('h18, addi(4, 0, -128));          // addi x4,x0,-128
    put('h1c, enc_s(8, 4, 0, 0));         // sb   x4,8(x0)
    put('h20, enc_i(8, 0, 0, 5, 'h03));   // lb   x5,8(x0)
    put('h24, enc_i(8, 0, 4, 6, 'h03));   // lbu  x6,8(x0)
    put('h28, enc_i(0, 0, 2, 7, 'h03));   // lw   x7,0(x0)
    put('h2c, enc_i(512, 0, 2, 8, 'h03)); // lw   x8,512(x0) wraps to 0
    put('h30, JSELF);
    reset_core();
    step(14);
    check("mem_loop_pc", dut.PC, 32'h30);
    check("dmem0", 32'(dut.U_DM.dmem[0]), 32'h78);
    check("dmem1", 32'(dut.U_DM.dmem[1]), 32'h56);
    check("dmem2", 32'(dut.U_DM.dmem[2]), 32'h34);
    check("dmem3", 32'(dut.U_DM.dmem[3]), 32'h12);
    check("dmem5_sb", 32'(dut.U_DM.dmem[5]), 32'h78);
    check("dmem8_sb", 32'(dut.U_DM.dmem[8]), 32'h80);
    check_reg("lb_pos", 2, 32'h0000_0078);
    check_reg("lbu_b3", 3, 32'h0000_0012);
    check_reg("lb_neg", 5, 32'hffff_ff80);
    check_reg("lbu_neg", 6, 32'h0000_0080);
    check_reg("lw", 7, 32'h1234_5678);
    check_reg("lw_wrap", 8, 32'h1234_5678);

    // ---------------- control flow ----------------
    rstn = 1'b1;
    clear_rom();
    put('h00, addi(1, 0, 1));
    put('h04, addi(9, 0, 7));
    put('h08, addi(2, 0, -1));
    put('h0c, enc_b(8, 1, 1, 0));         // beq  x1,x1,+8  taken
    put('h10, addi(9, 0, 99));
    put('h14, enc_b(8, 1, 1, 1));         // bne  x1,x1,+8  not taken
    put('h18, enc_b(8, 1, 2, 4));         // blt  x2,x1,+8  taken
    put('h1c, addi(9, 0, 98));
    put('h20, enc_b(8, 1, 2, 6));         // bltu x2,x1,+8  not taken
    put('h24, enc_b(8, 2, 1, 5));         // bge  x1,x2,+8  taken
    put('h28, addi(9, 0, 97));
    put('h2c, enc_j(8, 1));               // jal  x1,+8
    put('h30, enc_j(12, 0));              // jal  x0,+12
    put('h34, enc_i(0, 1, 0, 0, 'h67));   // jalr x0,0(x1)
    put('h38, addi(9, 0, 96));
    put('h3c, JSELF);
    pc_trace = '{32'h04, 32'h08, 32'h0c, 32'h14, 32'h18, 32'h20,
                 32'h24, 32'h2c, 32'h34, 32'h30, 32'h3c, 32'h3c};
    reset_core();
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("flow_pc_%0d", i), dut.PC, pc_trace[i]);
    end
    check_reg("jal_link", 1, 32'h30);
    check_reg("skipped_writes", 9, 32'd7);

    // ---------------- x0 and shifts ----------------
    rstn = 1'b1;
    clear_rom();
    put('h00, addi(0, 0, 7));
    put('h04, enc_u('h80000, 11, 'h37));          // lui  x11,0x80000
    put('h08, enc_i('h404, 11, 5, 12, 'h13));     // srai x12,x11,4
    put('h0c, enc_i(4, 11, 5, 13, 'h13));         // srli x13,x11,4
    put('h10, addi(14, 0, 3));
    put('h14, enc_r(0, 14, 14, 1, 15));           // sll  x15,x14,x14
    put('h18, enc_r('h20, 14, 11, 5, 16));        // sra  x16,x11,x14
    put('h1c, enc_i(-1, 14, 4, 17, 'h13));        // xori x17,x14,-1
    put('h20, enc_u(1, 18, 'h17));                // auipc x18,1
    put('h24, JSELF);
    reset_core();
    step(10);
    check_reg("x0_zero", 0, 32'd0);
    check_reg("srai", 12, 32'hf800_0000);
    check_reg("srli", 13, 32'h0800_0000);
    check_reg("sll", 15, 32'd24);
    check_reg("sra", 16, 32'hf000_0000);
    check_reg("xori", 17, 32'hffff_fffc);
    check_reg("auipc", 18, 32'h0000_1020);

    // ---------------- mid-run reset and ROM wrap ----------------
    rstn = 1'b1;
    clear_rom();
    put('h000, addi(19, 0, 1));
    put('h004, addi(19, 19, 1));
    put('h008, addi(19, 19, 1));
    put('h00c, enc_j('h7ec, 0));          // jal x0 -> 0x7f8
    put('h7f8, addi(20, 0, 5));
    put('h7fc, addi(20, 20, 1));
    reset_core();
    step(2);
    check("mid_pre_pc", dut.PC, 32'h8);
    check_reg("mid_pre_x19", 19, 32'd2);
    rstn = 1'b1;
    step(1);
    check("mid_reset_pc", dut.PC, 32'h0);
    check_reg("mid_reset_no_wr", 19, 32'd2);
    rstn = 1'b0;
    step(4);
    check("pc_7f8", dut.PC, 32'h7f8);
    check_reg("mid_post_x19", 19, 32'd3);
    step(2);
    check("pc_800", dut.PC, 32'h800);
    check("wrap_instr", dut.instr, 32'h0010_0993);
    check_reg("x20_end", 20, 32'd6);
    step(1);
    check("pc_804", dut.PC, 32'h804);
    check_reg("wrap_exec", 19, 32'd1);

    // ---------------- ecall / unsupported ----------------
    rstn = 1'b1;
    clear_rom();
    put('h00, addi(21, 0, 4));
    put('h04, 32'h0000_0073);             // ecall
    put('h08, 32'h0000_0a8b);             // custom-0 opcode, rd=x21
    put('h0c, JSELF);
    reset_core();
    step(4);
`ifdef SCCOMP_ECALL_HALT_EN
    check("ecall_halt_pc", dut.PC, 32'h4);
`else
    check("ecall_nop_pc", dut.PC, 32'hc);
`endif
    check_reg("unsup_no_wr", 21, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
